// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and width helper for the keypad lock.
package lock_pkg;
    typedef enum logic [1:0] {
        OPEN     = 2'b00,
        LOCKED   = 2'b01,
        UNLOCKED = 2'b10,
        LOCKOUT  = 2'b11
    } lock_state_t;

    // Bits needed to count 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/entry_buffer.sv
// entry_buffer: digit shift register (first digit most significant) with fill counter.
module entry_buffer import lock_pkg::*; #(
    parameter int DIGIT_W  = 4,
    parameter int CODE_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_i,
    input  logic                          enter_i,
    input  logic [DIGIT_W-1:0]            digit_i,
    output logic [cnt_w(CODE_LEN)-1:0]    index_o,
    output logic [DIGIT_W*CODE_LEN-1:0]   entry_o,
    output logic                          full_o
);
    localparam int IW = cnt_w(CODE_LEN);
    localparam int CW = DIGIT_W * CODE_LEN;

    logic [IW-1:0] index_q;
    logic [CW-1:0] entry_q;

    assign full_o  = index_q == IW'(CODE_LEN);
    assign index_o = index_q;
    assign entry_o = entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            entry_q <= '0;
        end else if (clr_i) begin
            index_q <= '0;
            entry_q <= '0;
        end else if (enter_i && !full_o) begin
            entry_q <= (entry_q << DIGIT_W) | CW'(digit_i);
            index_q <= index_q + 1'b1;
        end
    end
endmodule

// File: rtl/code_lock_core.sv
// code_lock_core: keypad lock FSM with stored user code, master code and timed lockout.
module code_lock_core import lock_pkg::*; #(
    parameter int                              DIGIT_W        = 4,
    parameter int                              CODE_LEN       = 4,
    parameter int                              MAX_FAILS      = 3,
    parameter int                              LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W*CODE_LEN-1:0]     MASTER_CODE    = '1
) (
    input  logic                               clk,
    input  logic                               master_rst_n,
    input  logic                               enter,
    input  logic [DIGIT_W-1:0]                 switch,
    input  logic                               clear,
    input  logic                               set_button,
    output logic [1:0]                         status,
    output logic [cnt_w(CODE_LEN)-1:0]         index,
    output logic [DIGIT_W*CODE_LEN-1:0]        entry,
    output logic                               is_set,
    output logic [cnt_w(MAX_FAILS)-1:0]        fail_count,
    output logic                               fail_pulse
);
    localparam int CW = DIGIT_W * CODE_LEN;
    localparam int FW = cnt_w(MAX_FAILS);
    localparam int TW = cnt_w(LOCKOUT_CYCLES);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);
    localparam logic [TW-1:0] T_LOAD   = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST   = TW'(1);

    lock_state_t   state_q;
    logic [CW-1:0] code_q;
    logic [FW-1:0] fails_q;
    logic [TW-1:0] timer_q;
    logic          is_set_q, fail_pulse_q;
    logic          full, set_ok, buf_clr, enter_ok, match;

    // In UNLOCKED an empty buffer relocks with the old code; a full one replaces it.
    always_comb begin
        set_ok   = set_button && !clear &&
                   ((state_q == OPEN && full) ||
                    (state_q == UNLOCKED && (full || index == '0)));
        buf_clr  = clear || set_ok || state_q == LOCKOUT || (state_q == LOCKED && full);
        enter_ok = enter && !clear && !set_button;
        match    = entry == code_q || entry == MASTER_CODE;
    end

    entry_buffer #(.DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN)) u_buf (
        .clk     (clk),
        .rst_n   (master_rst_n),
        .clr_i   (buf_clr),
        .enter_i (enter_ok),
        .digit_i (switch),
        .index_o (index),
        .entry_o (entry),
        .full_o  (full)
    );

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state_q      <= OPEN;
            code_q       <= '0;
            is_set_q     <= 1'b0;
            fails_q      <= '0;
            fail_pulse_q <= 1'b0;
            timer_q      <= '0;
        end else begin
            fail_pulse_q <= 1'b0;
            case (state_q)
                OPEN, UNLOCKED: if (set_ok) begin
                    if (full) begin
                        code_q   <= entry;
                        is_set_q <= 1'b1;
                    end
                    state_q <= LOCKED;
                end
                LOCKED: if (full) begin
                    if (match) begin
                        state_q <= UNLOCKED;
                        fails_q <= '0;
                    end else begin
                        fail_pulse_q <= 1'b1;
                        fails_q      <= fails_q + 1'b1;
                        if (fails_q + 1'b1 == FAIL_MAX) begin
                            state_q <= LOCKOUT;
                            timer_q <= T_LOAD;
                        end
                    end
                end
                LOCKOUT: if (timer_q == T_LAST) begin
                    state_q <= LOCKED;
                    fails_q <= '0;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q - 1'b1;
                end
                default: state_q <= OPEN;
            endcase
        end
    end

    assign status     = state_q;
    assign is_set     = is_set_q;
    assign fail_count = fails_q;
    assign fail_pulse = fail_pulse_q;
endmodule

// File: tb/tb_code_lock_core.sv
// tb_code_lock_core: directed stimulus with an event scoreboard for the keypad lock.
module tb_code_lock_core;
    typedef struct packed {
        logic [1:0] st;
        logic [1:0] fc;
        logic       fp;
        logic       set;
        logic [2:0] idx;
    } ev_t;

    logic        clk = 1'b0, master_rst_n = 1'b0;
    logic        enter = 1'b0, clear = 1'b0, set_button = 1'b0;
    logic [3:0]  switch = '0;
    logic [1:0]  status;
    logic [2:0]  index;
    logic [15:0] entry;
    logic        is_set;
    logic [1:0]  fail_count;
    logic        fail_pulse;

    code_lock_core #(
        .DIGIT_W(4), .CODE_LEN(4), .MAX_FAILS(3),
        .LOCKOUT_CYCLES(16), .MASTER_CODE(16'hFFFF)
    ) dut (
        .clk(clk), .master_rst_n(master_rst_n), .enter(enter), .switch(switch),
        .clear(clear), .set_button(set_button), .status(status), .index(index),
        .entry(entry), .is_set(is_set), .fail_count(fail_count), .fail_pulse(fail_pulse)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, lo_cnt = 0;
    ev_t  exp_q[$];
    ev_t  got, want;
    logic [1:0] prev_st = 2'b00;

    function automatic ev_t mk(input logic [1:0] st, input logic [1:0] fc, input logic fp, input logic set);
        return {st, fc, fp, set, 3'd0};
    endfunction

    // Monitor: every status change or fail pulse is an event matched against the queue.
    always @(negedge clk) begin
        got = {status, fail_count, fail_pulse, is_set, index};
        if (prev_st == 2'b11 && status == 2'b01) begin
            total++;
            if (lo_cnt != 16) begin
                bad++;
                $display("FAIL lockout_len: got %0d cycles want 16", lo_cnt);
            end
        end
        lo_cnt = (status == 2'b11) ? lo_cnt + 1 : 0;
        if (status !== prev_st || fail_pulse !== 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL event: unexpected %h at %0t", got, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL event: got st=%b fc=%0d fp=%b set=%b idx=%0d want st=%b fc=%0d fp=%b set=%b idx=%0d at %0t",
                             got.st, got.fc, got.fp, got.set, got.idx,
                             want.st, want.fc, want.fp, want.set, want.idx, $time);
                end
            end
        end
        prev_st = status;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        enter = 1'b1;
        switch = d;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic pulse_set();
        @(negedge clk);
        set_button = 1'b1;
        @(negedge clk);
        set_button = 1'b0;
    endtask

    task automatic code_in(input logic [15:0] c, input bit cmp, input ev_t e);
        for (int i = 3; i >= 0; i--) begin
            if (i == 0 && cmp) exp_q.push_back(e);
            press(c[i*4 +: 4]);
        end
        chk("idx_full", index, 4);
        if (cmp) begin
            @(negedge clk);
            chk("idx_after_cmp", index, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #2 master_rst_n = 1'b1;
        @(negedge clk);
        chk("rst_status", status, 0);
        chk("rst_index", index, 0);
        chk("rst_entry", entry, 0);
        chk("rst_is_set", is_set, 0);
        chk("rst_fail_count", fail_count, 0);
        chk("rst_fail_pulse", fail_pulse, 0);

        press(4'h5);
        press(4'h9);
        chk("partial_index", index, 2);
        chk("partial_entry", entry, 16'h0059);
        pulse_set();
        chk("set_partial_status", status, 0);
        chk("set_partial_index", index, 2);
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        chk("clear_index", index, 0);
        chk("clear_entry", entry, 0);
        @(negedge clk);
        enter = 1'b1;
        clear = 1'b1;
        switch = 4'h7;
        @(negedge clk);
        enter = 1'b0;
        clear = 1'b0;
        chk("enter_clear_index", index, 0);

        code_in(16'h59A1, 1'b0, '0);
        chk("entry_order", entry, 16'h59A1);
        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        pulse_set();
        chk("is_set_after_set", is_set, 1);
        code_in(16'h59A1, 1'b1, mk(2'b10, 2'd0, 1'b0, 1'b1));
        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        pulse_set();

        code_in(16'h1234, 1'b1, mk(2'b01, 2'd1, 1'b1, 1'b1));
        code_in(16'h1234, 1'b1, mk(2'b01, 2'd2, 1'b1, 1'b1));
        code_in(16'h1234, 1'b1, mk(2'b11, 2'd3, 1'b1, 1'b1));
        press(4'h3);
        press(4'h4);
        chk("lockout_enter_ignored", index, 0);
        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        repeat (16) @(negedge clk);
        chk("after_lockout_status", status, 2'b01);

        code_in(16'hFFFF, 1'b1, mk(2'b10, 2'd0, 1'b0, 1'b1));
        code_in(16'h1234, 1'b0, '0);
        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        pulse_set();
        code_in(16'h59A1, 1'b1, mk(2'b01, 2'd1, 1'b1, 1'b1));
        code_in(16'h1234, 1'b1, mk(2'b10, 2'd0, 1'b0, 1'b1));

        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        pulse_set();
        code_in(16'h0000, 1'b1, mk(2'b01, 2'd1, 1'b1, 1'b1));
        code_in(16'h0000, 1'b1, mk(2'b01, 2'd2, 1'b1, 1'b1));
        code_in(16'h0000, 1'b1, mk(2'b11, 2'd3, 1'b1, 1'b1));
        repeat (9) @(negedge clk);
        exp_q.push_back(mk(2'b00, 2'd0, 1'b0, 1'b0));
        #2 master_rst_n = 1'b0;
        #1;
        chk("midrst_status", status, 0);
        chk("midrst_is_set", is_set, 0);
        chk("midrst_fail_count", fail_count, 0);
        @(negedge clk);
        #2 master_rst_n = 1'b1;
        code_in(16'h59A1, 1'b0, '0);
        exp_q.push_back(mk(2'b01, 2'd0, 1'b0, 1'b1));
        pulse_set();
        code_in(16'h1234, 1'b1, mk(2'b01, 2'd1, 1'b1, 1'b1));
        code_in(16'h59A1, 1'b1, mk(2'b10, 2'd0, 1'b0, 1'b1));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
